stopwatch_cu: RTL and testbench

Control unit that sequences the stopwatch datapath from three raw push-buttons (run/stop, clear, lap).
- Synchronises and debounces each button, then edge-detects it into a one-cycle press pulse.
- A 3-state FSM produces the datapath's run_stop level and clear pulse.
- A lap-hold register freezes the displayed time while the datapath keeps counting.
- Sits between the board buttons and the stopwatch datapath / FND display mux.

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/stopwatch_cu_btn_debounce.sv | 69 ++++++
 rtl/stopwatch_cu.sv | 109 ++++++++++
 tb/tb_stopwatch_cu.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared encodings and field widths for the stopwatch control unit.
// Holds the FSM state type and the packed time record used by the lap latch.
package stopwatch_pkg;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic [MSEC_W-1:0] msec;
  } time_t;

endpackage

// File: rtl/stopwatch_cu_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability-counter debouncer and
// rising-edge detector producing a one-cycle press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             prev_q, prev_d;
  logic [1:0]       warm_q, warm_d;
  logic             armed_q, armed_d;

  always_comb begin
    sync1_d  = i_btn;
    sync2_d  = sync1_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    prev_d   = stable_q;
    warm_d   = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
    armed_d  = armed_q;

    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TERM) begin
      stable_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // A button held through reset must be seen released before it can
    // produce a press; arming waits until the synchroniser holds real samples.
    if (warm_q == 2'd2 && !sync2_q && !stable_q) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      warm_q   <= 2'd0;
      armed_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      warm_q   <= warm_d;
      armed_q  <= armed_d;
    end
  end

  assign o_pulse = stable_q & ~prev_q & armed_q;

endmodule

// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: debounced buttons drive a STOP/RUN/CLEAR FSM and a
// lap-hold latch that freezes the displayed time while the datapath counts on.
module stopwatch_cu
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_run,
  input  logic              btn_clear,
  input  logic              btn_lap,
  input  logic [MSEC_W-1:0] i_msec,
  input  logic [SEC_W-1:0]  i_sec,
  input  logic [MIN_W-1:0]  i_min,
  input  logic [HOUR_W-1:0] i_hour,
  output logic              run_stop,
  output logic              clear,
  output logic              lap_hold,
  output logic [MSEC_W-1:0] o_msec,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic [1:0]        dbg_state
);

  logic run_p, clear_p, lap_p;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk(clk), .rst(rst), .i_btn(btn_run), .o_pulse(run_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk(clk), .rst(rst), .i_btn(btn_clear), .o_pulse(clear_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk(clk), .rst(rst), .i_btn(btn_lap), .o_pulse(lap_p)
  );

  state_e state_q, state_d;
  logic   lap_hold_q, lap_hold_d;
  time_t  lap_q, lap_d;
  time_t  live;

  assign live = '{hour: i_hour, min: i_min, sec: i_sec, msec: i_msec};

  always_comb begin
    state_d    = state_q;
    lap_hold_d = lap_hold_q;
    lap_d      = lap_q;

    case (state_q)
      ST_STOP: begin
        if (lap_p) begin
          lap_hold_d = 1'b0;
        end
        if (clear_p) begin
          state_d    = ST_CLEAR;
          lap_hold_d = 1'b0;
        end else if (run_p) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // run/stop beats lap when both land together; clear is ignored here.
        if (run_p) begin
          state_d = ST_STOP;
        end else if (lap_p) begin
          lap_hold_d = ~lap_hold_q;
          if (!lap_hold_q) begin
            lap_d = live;
          end
        end
      end
      ST_CLEAR: begin
        state_d    = ST_STOP;
        lap_hold_d = 1'b0;
      end
      default: begin
        state_d    = ST_STOP;
        lap_hold_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_STOP;
      lap_hold_q <= 1'b0;
      lap_q      <= '0;
    end else begin
      state_q    <= state_d;
      lap_hold_q <= lap_hold_d;
      lap_q      <= lap_d;
    end
  end

  assign run_stop  = (state_q == ST_RUN);
  assign clear     = (state_q == ST_CLEAR);
  assign lap_hold  = lap_hold_q;
  assign dbg_state = state_q;

  assign o_msec = lap_hold_q ? lap_q.msec : i_msec;
  assign o_sec  = lap_hold_q ? lap_q.sec  : i_sec;
  assign o_min  = lap_hold_q ? lap_q.min  : i_min;
  assign o_hour = lap_hold_q ? lap_q.hour : i_hour;

endmodule

// File: tb/tb_stopwatch_cu.sv
// Self-checking bench for stopwatch_cu with a short debounce window.
module tb_stopwatch_cu;
  import stopwatch_pkg::*;

  localparam int DB = 4;

  logic              clk;
  logic              rst;
  logic              btn_run, btn_clear, btn_lap;
  logic [MSEC_W-1:0] i_msec;
  logic [SEC_W-1:0]  i_sec;
  logic [MIN_W-1:0]  i_min;
  logic [HOUR_W-1:0] i_hour;
  logic              run_stop, clear, lap_hold;
  logic [MSEC_W-1:0] o_msec;
  logic [SEC_W-1:0]  o_sec;
  logic [MIN_W-1:0]  o_min;
  logic [HOUR_W-1:0] o_hour;
  logic [1:0]        dbg_state;

  stopwatch_cu #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst),
    .btn_run(btn_run), .btn_clear(btn_clear), .btn_lap(btn_lap),
    .i_msec(i_msec), .i_sec(i_sec), .i_min(i_min), .i_hour(i_hour),
    .run_stop(run_stop), .clear(clear), .lap_hold(lap_hold),
    .o_msec(o_msec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [2:0]  exp_q[$];   // {run_stop, clear, lap_hold}
  logic [23:0] exp_d_q[$]; // {hour, min, sec, msec}
  logic [2:0]  got_c, exp_c;
  logic [23:0] got_d, exp_d;
  int clear_cnt = 0;
  int c0;

  always @(negedge clk) if (clear === 1'b1) clear_cnt++;

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: btn_run = v;
      1: btn_clear = v;
      default: btn_lap = v;
    endcase
  endtask

  task automatic press(input int which);
    set_btn(which, 1'b1);
    tick(10);
    set_btn(which, 1'b0);
    tick(8);
  endtask

  task automatic set_live(input int h, input int m, input int s, input int ms);
    i_hour = HOUR_W'(h);
    i_min  = MIN_W'(m);
    i_sec  = SEC_W'(s);
    i_msec = MSEC_W'(ms);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    btn_run = 1'b1; btn_clear = 1'b1; btn_lap = 1'b1;
    set_live(2, 17, 45, 88);
    #23;
    exp_q.push_back(3'b000);
    got_c = {run_stop, clear, lap_hold}; exp_c = exp_q.pop_front(); total_cnt++;
    if (got_c !== exp_c) $display("FAIL reset_ctrl got=%b exp=%b", got_c, exp_c); else pass_cnt++;
    exp_d_q.push_back({5'd2, 6'd17, 6'd45, 7'd88});
    got_d = {o_hour, o_min, o_sec, o_msec}; exp_d = exp_d_q.pop_front(); total_cnt++;
    if (got_d !== exp_d) $display("FAIL reset_live got=%h exp=%h", got_d, exp_d); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b1;
    c0 = clear_cnt;
    tick(15);
    exp_q.push_back(3'b000);
    got_c = {run_stop, clear, lap_hold}; exp_c = exp_q.pop_front(); total_cnt++;
    if (got_c !== exp_c) $display("FAIL held_release_ctrl got=%b exp=%b", got_c, exp_c); else pass_cnt++;
    total_cnt++;
    if (clear_cnt - c0 !== 0) $display("FAIL held_release_clear got=%0d exp=0", clear_cnt - c0); else pass_cnt++;
    btn_run = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
    tick(10);
    total_cnt++;
    if (dbg_state !== ST_STOP) $display("FAIL held_release_state got=%0d exp=%0d", dbg_state, ST_STOP); else pass_cnt++;
  endtask

  task automatic test_debounce;
    btn_run = 1'b1;
    tick(3);
    btn_run = 1'b0;
    tick(10);
    exp_q.push_back(3'b000);
    got_c = {run_stop, clear, lap_hold}; exp_c = exp_q.pop_front(); total_cnt++;
    if (got_c !== exp_c) $display("FAIL glitch got=%b exp=%b", got_c, exp_c); else pass_cnt++;
    btn_run = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      exp_q.push_back({(k == 7), 2'b00});
      got_c = {run_stop, clear, lap_hold}; exp_c = exp_q.pop_front(); total_cnt++;
      if (got_c !== exp_c) $display("FAIL latency_edge%0d got=%b exp=%b", k, got_c, exp_c); else pass_cnt++;
    end
    tick(3);
    btn_run = 1'b0;
    tick(8);
    exp_q.push_back(3'b100);
    got_c = {run_stop, clear, lap_hold}; exp_c = exp_q.pop_front(); total_cnt++;
    if (got_c !== exp_c) $display("FAIL release_no_pulse got=%b exp=%b", got_c, exp_c); else pass_cnt++;
    press(0);
    exp_q.push_back(3'b000);
    got_c = {run_stop, clear, lap_hold}; exp_c = exp_q.pop_front(); total_cnt++;
    if (got_c !== exp_c) $display("FAIL second_press_stop got=%b exp=%b", got_c, exp_c); else pass_cnt++;
  endtask

  task automatic test_clear_priority;
    c0 = clear_cnt;
    btn_run = 1'b1; btn_clear = 1'b1;
    tick(6);
    exp_q.push_back(3'b000);
    got_c = {run_stop, clear, lap_hold}; exp_c = exp_q.pop_front(); total_cnt++;
    if (got_c !== exp_c) $display("FAIL prio_before got=%b exp=%b", got_c, exp_c); else pass_cnt++;
    tick(1);
    exp_q.push_back(3'b010);
    got_c = {run_stop, clear, lap_hold}; exp_c = exp_q.pop_front(); total_cnt++;
    if (got_c !== exp_c) $display("FAIL prio_clear got=%b exp=%b", got_c, exp_c); else pass_cnt++;
    tick(1);
    exp_q.push_back(3'b000);
    got_c = {run_stop, clear, lap_hold}; exp_c = exp_q.pop_front(); total_cnt++;
    if (got_c !== exp_c) $display("FAIL prio_after got=%b exp=%b", got_c, exp_c); else pass_cnt++;
    total_cnt++;
    if (dbg_state !== ST_STOP) $display("FAIL prio_state got=%0d exp=%0d", dbg_state, ST_STOP); else pass_cnt++;
    btn_run = 1'b0; btn_clear = 1'b0;
    tick(8);
    total_cnt++;
    if (clear_cnt - c0 !== 1) $display("FAIL prio_width got=%0d exp=1", clear_cnt - c0); else pass_cnt++;
    press(0);
    c0 = clear_cnt;
    press(1);
    exp_q.push_back(3'b100);
    got_c = {run_stop, clear, lap_hold}; exp_c = exp_q.pop_front(); total_cnt++;
    if (got_c !== exp_c) $display("FAIL run_clear_ignored got=%b exp=%b", got_c, exp_c); else pass_cnt++;
    total_cnt++;
    if (clear_cnt - c0 !== 0) $display("FAIL run_clear_pulse got=%0d exp=0", clear_cnt - c0); else pass_cnt++;
  endtask

  task automatic test_lap;
    set_live(1, 3, 12, 34);
    press(2);
    exp_q.push_back(3'b101);
    got_c = {run_stop, clear, lap_hold}; exp_c = exp_q.pop_front(); total_cnt++;
    if (got_c !== exp_c) $display("FAIL lap_on got=%b exp=%b", got_c, exp_c); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      set_live(1, 3, 13 + k, $urandom_range(0, 99));
      tick(1);
      exp_d_q.push_back({5'd1, 6'd3, 6'd12, 7'd34});
      got_d = {o_hour, o_min, o_sec, o_msec}; exp_d = exp_d_q.pop_front(); total_cnt++;
      if (got_d !== exp_d) $display("FAIL lap_frozen%0d got=%h exp=%h", k, got_d, exp_d); else pass_cnt++;
    end
    press(0);
    exp_q.push_back(3'b001);
    got_c = {run_stop, clear, lap_hold}; exp_c = exp_q.pop_front(); total_cnt++;
    if (got_c !== exp_c) $display("FAIL lap_stop got=%b exp=%b", got_c, exp_c); else pass_cnt++;
    exp_d_q.push_back({5'd1, 6'd3, 6'd12, 7'd34});
    got_d = {o_hour, o_min, o_sec, o_msec}; exp_d = exp_d_q.pop_front(); total_cnt++;
    if (got_d !== exp_d) $display("FAIL lap_stop_frozen got=%h exp=%h", got_d, exp_d); else pass_cnt++;
    press(2);
    exp_q.push_back(3'b000);
    got_c = {run_stop, clear, lap_hold}; exp_c = exp_q.pop_front(); total_cnt++;
    if (got_c !== exp_c) $display("FAIL lap_off got=%b exp=%b", got_c, exp_c); else pass_cnt++;
    set_live(4, 22, 59, 7);
    #1;
    exp_d_q.push_back({5'd4, 6'd22, 6'd59, 7'd7});
    got_d = {o_hour, o_min, o_sec, o_msec}; exp_d = exp_d_q.pop_front(); total_cnt++;
    if (got_d !== exp_d) $display("FAIL lap_off_live got=%h exp=%h", got_d, exp_d); else pass_cnt++;
  endtask

  task automatic test_clear_drops_lap;
    set_live(0, 5, 6, 70);
    press(0);
    press(2);
    press(0);
    exp_q.push_back(3'b001);
    got_c = {run_stop, clear, lap_hold}; exp_c = exp_q.pop_front(); total_cnt++;
    if (got_c !== exp_c) $display("FAIL cdl_setup got=%b exp=%b", got_c, exp_c); else pass_cnt++;
    btn_clear = 1'b1;
    tick(7);
    exp_q.push_back(3'b010);
    got_c = {run_stop, clear, lap_hold}; exp_c = exp_q.pop_front(); total_cnt++;
    if (got_c !== exp_c) $display("FAIL cdl_pulse got=%b exp=%b", got_c, exp_c); else pass_cnt++;
    tick(1);
    exp_q.push_back(3'b000);
    got_c = {run_stop, clear, lap_hold}; exp_c = exp_q.pop_front(); total_cnt++;
    if (got_c !== exp_c) $display("FAIL cdl_after got=%b exp=%b", got_c, exp_c); else pass_cnt++;
    btn_clear = 1'b0;
    tick(8);
  endtask

  task automatic test_async_reset;
    set_live(2, 9, 30, 15);
    press(0);
    press(2);
    set_live(2, 9, 31, 50);
    exp_q.push_back(3'b101);
    got_c = {run_stop, clear, lap_hold}; exp_c = exp_q.pop_front(); total_cnt++;
    if (got_c !== exp_c) $display("FAIL ar_setup got=%b exp=%b", got_c, exp_c); else pass_cnt++;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    exp_q.push_back(3'b000);
    got_c = {run_stop, clear, lap_hold}; exp_c = exp_q.pop_front(); total_cnt++;
    if (got_c !== exp_c) $display("FAIL ar_ctrl got=%b exp=%b", got_c, exp_c); else pass_cnt++;
    exp_d_q.push_back({5'd2, 6'd9, 6'd31, 7'd50});
    got_d = {o_hour, o_min, o_sec, o_msec}; exp_d = exp_d_q.pop_front(); total_cnt++;
    if (got_d !== exp_d) $display("FAIL ar_live got=%h exp=%h", got_d, exp_d); else pass_cnt++;
    tick(2);
    rst = 1'b1;
    tick(5);
    total_cnt++;
    if (dbg_state !== ST_STOP) $display("FAIL ar_state got=%0d exp=%0d", dbg_state, ST_STOP); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_clear_priority();
    test_lap();
    test_clear_drops_lap();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
